// File: rtl/iomem_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : iomem_arb_pkg                                                    |
// | Purpose  : Shared types and constants for the scalar/vector memory arbiter. |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
package iomem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   localparam logic PORT_SCALAR = 1'b0;
   localparam logic PORT_VECTOR = 1'b1;

   localparam int ADDR_W   = 32;
   localparam int SDATA_W  = 32;
   localparam int VWDATA_W = 64;
   localparam int VRDATA_W = 128;

endpackage : iomem_arb_pkg
`default_nettype wire

// File: rtl/iomem_arb_select.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : iomem_arb_select                                                 |
// | Purpose  : Picks the owner of the next transaction from two requesters.     |
// |            IOMEM_ARB_RR_EN selects round-robin, otherwise port 0 wins.      |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module iomem_arb_select
   import iomem_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_owner,
   output logic valid,
   output logic owner
);

`ifdef IOMEM_ARB_RR_EN
   always_comb begin
      valid = req0 | req1;
      owner = PORT_SCALAR;
      if (req0 && req1)
         owner = ~last_owner;
      else if (req1)
         owner = PORT_VECTOR;
   end
`else
   // Fixed priority never looks at history.
   logic w_unused_last;
   assign w_unused_last = last_owner;

   always_comb begin
      valid = req0 | req1;
      owner = PORT_SCALAR;
      if (!req0 && req1)
         owner = PORT_VECTOR;
   end
`endif

endmodule : iomem_arb_select
`default_nettype wire

// File: rtl/iomem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : iomem_arbiter                                                    |
// | Purpose  : Shares one memory port between a scalar and a vector requester,  |
// |            one transaction in flight. Macro: IOMEM_ARB_RR_EN (round-robin). |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module iomem_arbiter
   import iomem_arb_pkg::*;
#(
   parameter int READ_LAT = 1
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                p0_req,
   input  logic                p0_we,
   input  logic [ADDR_W-1:0]   p0_addr,
   input  logic [SDATA_W-1:0]  p0_wdata,
   output logic                p0_gnt,
   output logic                p0_rvalid,
   output logic [SDATA_W-1:0]  p0_rdata,
   input  logic                p1_req,
   input  logic                p1_we,
   input  logic [ADDR_W-1:0]   p1_addr,
   input  logic [VWDATA_W-1:0] p1_wdata,
   output logic                p1_gnt,
   output logic                p1_rvalid,
   output logic [VRDATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [SDATA_W-1:0]  mem_data_input,
   output logic                mem_write_enable,
   output logic [VWDATA_W-1:0] mem_vector_input,
   input  logic [SDATA_W-1:0]  mem_data_output,
   input  logic [VRDATA_W-1:0] mem_vector_output
);

   // WAIT exits when the counter reaches zero, so it is preloaded with READ_LAT-2.
   localparam logic [1:0] c_wait_init = (READ_LAT >= 2) ? 2'(READ_LAT - 2) : 2'd0;

   arb_state_t  r_state;
   arb_state_t  w_next_state;
   logic        r_owner;
   logic        r_we;
   logic [1:0]  r_cnt;
   logic        w_valid;
   logic        w_owner;
   logic        w_last_owner;
   logic        w_capture;
   logic        w_sel_we;

`ifdef IOMEM_ARB_RR_EN
   // r_prio is the port that wins the next tie; the selector wants the last winner.
   logic r_prio;

   always_ff @(posedge clk) begin
      if (rst)
         r_prio <= PORT_SCALAR;
      else if (w_capture)
         r_prio <= ~w_owner;
   end

   assign w_last_owner = ~r_prio;
`else
   assign w_last_owner = PORT_VECTOR;
`endif

   iomem_arb_select u_select (
      .req0       (p0_req),
      .req1       (p1_req),
      .last_owner (w_last_owner),
      .valid      (w_valid),
      .owner      (w_owner)
   );

   assign w_sel_we = (w_owner == PORT_VECTOR) ? p1_we : p0_we;

   always_comb begin
      w_next_state = r_state;
      w_capture    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_valid) begin
               w_capture    = 1'b1;
               w_next_state = ISSUE;
            end
         end
         ISSUE: begin
            if (r_we)
               w_next_state = IDLE;
            else if (READ_LAT == 1)
               w_next_state = RESP;
            else
               w_next_state = WAIT;
         end
         WAIT: begin
            if (r_cnt == 2'd0)
               w_next_state = RESP;
         end
         RESP: begin
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= IDLE;
         r_owner          <= PORT_SCALAR;
         r_we             <= 1'b0;
         r_cnt            <= 2'd0;
         p0_gnt           <= 1'b0;
         p1_gnt           <= 1'b0;
         p0_rvalid        <= 1'b0;
         p1_rvalid        <= 1'b0;
         p0_rdata         <= '0;
         p1_rdata         <= '0;
         mem_address      <= '0;
         mem_data_input   <= '0;
         mem_vector_input <= '0;
         mem_write_enable <= 1'b0;
      end else begin
         r_state <= w_next_state;

         // Grant and strobe are registered off the capture so they line up with ISSUE.
         p0_gnt           <= w_capture && (w_owner == PORT_SCALAR);
         p1_gnt           <= w_capture && (w_owner == PORT_VECTOR);
         mem_write_enable <= w_capture && w_sel_we;

         p0_rvalid <= (r_state == RESP) && (r_owner == PORT_SCALAR);
         p1_rvalid <= (r_state == RESP) && (r_owner == PORT_VECTOR);

         if (w_capture) begin
            r_owner <= w_owner;
            r_we    <= w_sel_we;
            if (w_owner == PORT_VECTOR) begin
               mem_address      <= p1_addr;
               mem_vector_input <= p1_wdata;
            end else begin
               mem_address    <= p0_addr;
               mem_data_input <= p0_wdata;
            end
         end

         if (r_state == ISSUE)
            r_cnt <= c_wait_init;
         else if (r_state == WAIT)
            r_cnt <= r_cnt - 2'd1;

         if (r_state == RESP) begin
            if (r_owner == PORT_VECTOR)
               p1_rdata <= mem_vector_output;
            else
               p0_rdata <= mem_data_output;
         end
      end
   end

endmodule : iomem_arbiter
`default_nettype wire

// File: tb/tb_iomem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_iomem_arbiter                                                 |
// | Purpose  : Directed bench for iomem_arbiter at READ_LAT=1 and READ_LAT=3.   |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_iomem_arbiter;

   logic         clk;
   logic         rst;
   logic         p0_req, p0_we, p1_req, p1_we;
   logic [31:0]  p0_addr, p0_wdata, p1_addr;
   logic [63:0]  p1_wdata;

   // READ_LAT=1 instance
   logic         p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, mem_we;
   logic [31:0]  p0_rdata, mem_addr, mem_din, mem_dout;
   logic [127:0] p1_rdata, mem_vout;
   logic [63:0]  mem_vin;

   // READ_LAT=3 instance
   logic         d3_p0_gnt, d3_p0_rvalid, d3_p1_gnt, d3_p1_rvalid, d3_we;
   logic [31:0]  d3_p0_rdata, d3_addr, d3_din, m3_dout;
   logic [127:0] d3_p1_rdata, m3_vout;
   logic [63:0]  d3_vin;

   int checks = 0;
   int errors = 0;

   iomem_arbiter #(.READ_LAT(1)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .mem_address(mem_addr), .mem_data_input(mem_din), .mem_write_enable(mem_we),
      .mem_vector_input(mem_vin), .mem_data_output(mem_dout), .mem_vector_output(mem_vout)
   );

   iomem_arbiter #(.READ_LAT(3)) dut3 (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(d3_p0_gnt), .p0_rvalid(d3_p0_rvalid), .p0_rdata(d3_p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(d3_p1_gnt), .p1_rvalid(d3_p1_rvalid), .p1_rdata(d3_p1_rdata),
      .mem_address(d3_addr), .mem_data_input(d3_din), .mem_write_enable(d3_we),
      .mem_vector_input(d3_vin), .mem_data_output(m3_dout), .mem_vector_output(m3_vout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   int          gcnt;
   int          gown [0:7];
   int          gcyc [0:7];
   int          exp_own [0:2];
   logic [127:0] vval;

   initial begin
      rst = 1'b1;
      p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
      p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
      mem_dout = 0; mem_vout = 0; m3_dout = 0; m3_vout = 0;
      step(); step();
      rst = 1'b0;

      // Reset state
      chk("rst_p0_gnt", p0_gnt, 0);
      chk("rst_p1_gnt", p1_gnt, 0);
      chk("rst_p0_rvalid", p0_rvalid, 0);
      chk("rst_p1_rvalid", p1_rvalid, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_din", mem_din, 0);
      chk("rst_mem_vin", mem_vin, 0);
      chk("rst_p0_rdata", p0_rdata, 0);
      chk("rst_p1_rdata", p1_rdata, 0);

      // p0 read of 0x10, memory returns 0xDEADBEEF
      p0_req = 1; p0_we = 0; p0_addr = 32'h10;
      step();
      chk("rd0_gnt", p0_gnt, 1);
      chk("rd0_p1_gnt", p1_gnt, 0);
      chk("rd0_we", mem_we, 0);
      chk("rd0_addr", mem_addr, 32'h10);
      step();
      p0_req = 0;
      mem_dout = 32'hDEADBEEF;
      chk("rd0_gnt_pulse", p0_gnt, 0);
      chk("rd0_rvalid_early", p0_rvalid, 0);
      step();
      mem_dout = 32'h13579BDF;
      chk("rd0_rvalid", p0_rvalid, 1);
      chk("rd0_rdata", p0_rdata, 32'hDEADBEEF);
      step();
      chk("rd0_rvalid_pulse", p0_rvalid, 0);
      chk("rd0_rdata_hold", p0_rdata, 32'hDEADBEEF);

      // p1 vector write
      p1_req = 1; p1_we = 1; p1_addr = 32'h40; p1_wdata = 64'h1122334455667788;
      step();
      chk("wr1_gnt", p1_gnt, 1);
      chk("wr1_we", mem_we, 1);
      chk("wr1_addr", mem_addr, 32'h40);
      chk("wr1_vin", mem_vin, 64'h1122334455667788);
      step();
      p1_req = 0; p1_we = 0;
      chk("wr1_we_pulse", mem_we, 0);
      chk("wr1_gnt_pulse", p1_gnt, 0);
      chk("wr1_vin_hold", mem_vin, 64'h1122334455667788);
      chk("wr1_no_rvalid_a", p1_rvalid, 0);
      step();
      chk("wr1_no_rvalid_b", p1_rvalid, 0);
      chk("wr1_no_rvalid_p0", p0_rvalid, 0);

      // Simultaneous held reads: grant order depends on arbitration mode
      vval = 128'hA5A5_0001_B6B6_0002_C7C7_0003_D8D8_0004;
      mem_vout = vval;
      mem_dout = 32'h0000_5A5A;
      p0_req = 1; p0_addr = 32'h100; p1_req = 1; p1_addr = 32'h200;
      gcnt = 0;
      for (int k = 1; k <= 10; k++) begin
         step();
         chk("both_gnt_excl", p0_gnt & p1_gnt, 0);
         if ((p0_gnt || p1_gnt) && gcnt < 8) begin
            gown[gcnt] = p1_gnt ? 1 : 0;
            gcyc[gcnt] = k;
            gcnt++;
         end
      end
      p0_req = 0; p1_req = 0;
`ifdef IOMEM_ARB_RR_EN
      exp_own[0] = 0; exp_own[1] = 1; exp_own[2] = 0;
`else
      exp_own[0] = 0; exp_own[1] = 0; exp_own[2] = 0;
`endif
      chk("arb_grant_count", 128'(gcnt >= 3), 1);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("arb_owner_%0d", i), 128'(gown[i]), 128'(exp_own[i]));
         chk($sformatf("arb_cycle_%0d", i), 128'(gcyc[i]), 128'(1 + 3 * i));
      end
      for (int k = 0; k < 5; k++) step();
      chk("arb_p0_rdata", p0_rdata, 32'h0000_5A5A);
`ifdef IOMEM_ARB_RR_EN
      chk("arb_p1_rdata", p1_rdata, vval);
`else
      chk("arb_p1_rdata", p1_rdata, 0);
`endif

      // READ_LAT=3 vector read on dut3
      rst = 1; mem_vout = 0; mem_dout = 0;
      step();
      rst = 0;
      vval = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      p1_req = 1; p1_we = 0; p1_addr = 32'h80;
      for (int k = 1; k <= 6; k++) begin
         step();
         if (k == 2) p1_req = 0;
         m3_vout = (k == 4) ? vval : 128'h0;
         chk($sformatf("l3_p1_gnt_k%0d", k), d3_p1_gnt, (k == 1));
         chk($sformatf("l3_p1_rvalid_k%0d", k), d3_p1_rvalid, (k == 5));
         chk($sformatf("l3_p0_rvalid_k%0d", k), d3_p0_rvalid, 0);
         if (k == 5) chk("l3_p1_rdata", d3_p1_rdata, vval);
      end

      // Reset during WAIT of a p0 read on dut3
      m3_dout = 32'h7777_7777;
      p0_req = 1; p0_we = 0; p0_addr = 32'h20;
      step();
      chk("ab_gnt", d3_p0_gnt, 1);
      step();
      p0_req = 0;
      rst = 1;
      step();
      rst = 0;
      chk("ab_we", d3_we, 0);
      chk("ab_p0_gnt", d3_p0_gnt, 0);
      chk("ab_p1_gnt", d3_p1_gnt, 0);
      chk("ab_p0_rvalid", d3_p0_rvalid, 0);
      chk("ab_p1_rvalid", d3_p1_rvalid, 0);
      chk("ab_addr", d3_addr, 0);
      chk("ab_din", d3_din, 0);
      chk("ab_vin", d3_vin, 0);
      chk("ab_p0_rdata", d3_p0_rdata, 0);
      chk("ab_p1_rdata", d3_p1_rdata, 0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("ab_no_rvalid", d3_p0_rvalid, 0);
      end

      // Next p0 read after the abort is served normally
      m3_dout = 0;
      p0_req = 1; p0_addr = 32'h24;
      for (int k = 1; k <= 6; k++) begin
         step();
         if (k == 2) p0_req = 0;
         m3_dout = (k == 4) ? 32'hCAFEF00D : 32'h0;
         chk($sformatf("re_gnt_k%0d", k), d3_p0_gnt, (k == 1));
         chk($sformatf("re_rvalid_k%0d", k), d3_p0_rvalid, (k == 5));
         if (k == 1) chk("re_addr", d3_addr, 32'h24);
         if (k == 5) chk("re_rdata", d3_p0_rdata, 32'hCAFEF00D);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_iomem_arbiter
`default_nettype wire

// File: doc/iomem_arbiter.md
IOMEM_ARBITER -- requirements
Module: iomem_arbiter

Interface
REQ-001 The block SHALL have one parameter: READ_LAT, default 1, meaning memory read latency in clk cycles from the issue cycle to valid memory read data, legal range 1..4.
REQ-002 The block SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-003 The block SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-004 The block SHALL have ports: p0_req/p0_we  in  1/1  scalar requester request / write select.
REQ-005 The block SHALL have ports: p0_addr, p0_wdata  in  32/32  scalar address / write data.
REQ-006 The block SHALL have ports: p0_gnt, p0_rvalid  out  1/1  scalar grant pulse / read-data-valid pulse.
REQ-007 The block SHALL have ports: p0_rdata  out  32  scalar read data.
REQ-008 The block SHALL have ports: p1_req/p1_we  in  1/1  vector requester request / write select.
REQ-009 The block SHALL have ports: p1_addr, p1_wdata  in  32/64  vector address / vector write data.
REQ-010 The block SHALL have ports: p1_gnt, p1_rvalid  out  1/1  vector grant pulse / read-data-valid pulse.
REQ-011 The block SHALL have ports: p1_rdata  out  128  vector read data.
REQ-012 The block SHALL have ports: mem_address, mem_data_input  out  32/32  shared memory port address / scalar write data.
REQ-013 The block SHALL have ports: mem_write_enable  out  1  memory write strobe.
REQ-014 The block SHALL have ports: mem_vector_input  out  64  memory vector write data.
REQ-015 The block SHALL have ports: mem_data_output, mem_vector_output  in  32/128  memory read data.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP; there SHALL be exactly one outstanding transaction.
REQ-017 In IDLE with any req high, the FSM SHALL select an owner, capture its we/addr/wdata, and go to ISSUE next cycle.
REQ-018 In ISSUE, the block SHALL drive the captured request on mem_*, pulse the owner's gnt for exactly one cycle, and drive mem_write_enable = captured we.
REQ-019 After a write ISSUE, the FSM SHALL go to IDLE; after a read ISSUE, it SHALL go to WAIT, or to RESP when READ_LAT = 1.
REQ-020 WAIT SHALL count READ_LAT-1 cycles using a 2-bit down-counter, then go to RESP.
REQ-021 In RESP, the block SHALL register mem_data_output into p0_rdata (owner 0) or mem_vector_output into p1_rdata (owner 1), pulse that port's rvalid one cycle later for exactly one cycle, then return to IDLE.
REQ-022 Read latency SHALL be: req at cycle t -> gnt at t+1 -> rvalid at t+2+READ_LAT (default t+3).
REQ-023 Write latency SHALL be: req at t -> gnt and mem_write_enable at t+1 -> the earliest next grant at t+3.
REQ-024 Requesters SHALL hold req/we/addr/wdata stable until gnt and SHALL drop req in the cycle after gnt; a req still high in IDLE is treated as a new request.
REQ-025 Outside ISSUE, the block SHALL hold mem_write_enable at 0 and mem_address/mem_data_input/mem_vector_input at their last value.
REQ-026 rdata registers SHALL hold their value until the next read for the same port.
REQ-027 Address and data SHALL pass through unmodified, with no width conversion other than port selection.

Reset
REQ-028 Reset SHALL force: state IDLE; all gnt/rvalid 0; mem_write_enable 0; mem_address, mem_data_input, mem_vector_input, p0_rdata and p1_rdata all 0; priority pointer = port 0.
REQ-029 Reset asserted mid-transaction SHALL abort the transaction; no rvalid SHALL be emitted for the aborted read, and mem_write_enable SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-030 With macro IOMEM_ARB_RR_EN defined, simultaneous requests in IDLE SHALL be granted round-robin: the port not granted last wins, and the pointer updates on every grant.
REQ-031 With IOMEM_ARB_RR_EN undefined, port 0 SHALL always win simultaneous requests (fixed priority), and no pointer register SHALL exist.

Structure
REQ-032 Package iomem_arb_pkg SHALL hold: the state enum typedef; the owner constants PORT_SCALAR=0 and PORT_VECTOR=1; and the localparams ADDR_W=32, SDATA_W=32, VWDATA_W=64, VRDATA_W=128.
REQ-033 Owner selection SHALL live in one sub-module, iomem_arb_select, taking (req0, req1, last_owner) and producing (valid, owner), with the RR/fixed behaviour under the macro.

Verification
REQ-034 Reset, then p0 read addr 0x10 at t, with memory returning 0xDEADBEEF -> p0_gnt at t+1, mem_write_enable=0, p0_rvalid at t+3 with p0_rdata=0xDEADBEEF.
REQ-035 p1 write addr 0x40, wdata 0x1122334455667788 -> at grant: mem_write_enable=1 for one cycle, mem_vector_input=0x1122334455667788, no p1_rvalid.
REQ-036 p0 and p1 read simultaneously and held with RR_EN -> grant order p0, p1, p0; without the macro -> p0, p0, p0 while p0 is held.
REQ-037 READ_LAT=3, p1 read -> p1_rvalid exactly 5 cycles after p1 req, p1_rdata = 128-bit memory value, p0_rvalid stays 0.
REQ-038 rst asserted during WAIT of a p0 read -> no p0_rvalid, state IDLE, all outputs at reset values, and the next p0 request is served normally.
